pic_ctrl_core: RTL and testbench
================================

Name: pic_ctrl_core

Overview:
Clocked, parametrised interrupt-controller core. It replaces the event-driven control logic of the PIC with a single-clock synchronous design. It holds IRR, ISR and IMR-gated priority resolution with rotating priority, runs the two-pulse INTA sequence, generates the vector, and handles normal EOI, specific EOI and AEOI. It sits between the read/write command decoder (which supplies configuration and EOI commands) and the CPU interface (INT/INTA/data bus).

Parameters:
- NUM_IR, 8, number of interrupt inputs; must be a power of 2 in the range 2..32.
- VEC_W, 8, vector width.
- IDX_W, $clog2(NUM_IR), index width; derived and not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_req  in  NUM_IR  interrupt request lines, already synchronised.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- aeoi_en  in  1  automatic EOI at the end of the second INTA.
- imr  in  NUM_IR  mask; 1 = masked.
- vec_base  in  VEC_W  vector base from ICW2. The low IDX_W bits are ignored.
- inta_pulse  in  1  one-cycle pulse per CPU INTA strobe.
- eoi_cmd  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  qualifies eoi_cmd: 1 = specific EOI, 0 = non-specific EOI.
- eoi_level  in  IDX_W  target level for a specific EOI.
- rotate_en  in  1  qualifies eoi_cmd, and AEOI when it is set: rotate priority on clear.
- int_out  out  1  interrupt request to the CPU.
- vec_out  out  VEC_W  vector driven during the second INTA.
- vec_valid  out  1  one-cycle qualifier for vec_out.
- irr  out  NUM_IR  interrupt request register.
- isr  out  NUM_IR  in-service register.
- low_prio  out  IDX_W  current lowest-priority level.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - irr = 0, isr = 0, ir_prev = 0.
  - low_prio = NUM_IR-1, so IR0 has the highest priority.
  - int_out = 0, vec_out = 0, vec_valid = 0.
  - state = IDLE.
- Priority order: highest level is (low_prio+1) mod NUM_IR, then ascending with wrap-around; low_prio is the lowest. All modulo arithmetic is IDX_W bits wide and wraps naturally.
- IRR update, every cycle:
  - Edge mode: bit i is set when ir_prev[i] = 0 and ir_req[i] = 1.
  - Level mode: bit i is set while ir_req[i] = 1, and cleared when ir_req[i] = 0 and the bit is not being acknowledged.
  - In both modes the bit is cleared on the ACK1 acknowledge of that level.
  - ir_prev <= ir_req.
- Resolution (combinational):
  - pend = irr & ~imr.
  - win = highest-priority set bit of pend.
  - top_isr = highest-priority set bit of isr.
- int_out (registered): next value = 1 when pend != 0 and (isr == 0 or win is strictly higher in priority than top_isr). Otherwise 0.
- FSM states: IDLE, ACK1, ACK2.
  - IDLE, inta_pulse:
    - Latch idx = win.
    - If pend != 0: set isr[win] and clear irr[win].
    - If pend == 0 (spurious): set idx = NUM_IR-1 and change no ISR/IRR bit.
    - Go to ACK1.
  - ACK1, inta_pulse:
    - vec_out = {vec_base[VEC_W-1:IDX_W], idx}; vec_valid = 1 for exactly one cycle.
    - If aeoi_en and not spurious: clear isr[idx]; if rotate_en also set, low_prio = idx.
    - Go to IDLE.
  - Latency: vec_out and vec_valid are registered, valid the cycle after the second inta_pulse.
  - int_out is forced to 0 from the first inta_pulse until the cycle after vec_valid; it then re-evaluates.
  - inta_pulse in ACK2 never occurs: ACK2 is a reserved encoding that returns to IDLE.
- EOI, on eoi_cmd:
  - Non-specific: clear isr[top_isr]. No-op if isr == 0.
  - Specific: clear isr[eoi_level].
  - If rotate_en: low_prio = the cleared level. If nothing was cleared, low_prio is unchanged.
- Simultaneous events:
  - eoi_cmd together with the first inta_pulse: the EOI clear and the ISR set are both applied. If they target the same bit, set wins. top_isr is evaluated on the pre-update isr.
  - Simultaneous edge arrival and acknowledge on the same level: acknowledge wins and the bit clears.
- vec_base, ltim and imr may change at any time and take effect the next cycle. Changing ltim does not clear irr.
- Reset mid-sequence aborts to IDLE with all state cleared. No vector is emitted.

Test Plan:
- Reset, then ir_req = 8'h04 (edge mode), imr = 0, vec_base = 8'hA8 -> irr = 8'h04 and int_out = 1. Two inta_pulses -> isr = 8'h04, irr = 0, vec_out = 8'hAA with a single vec_valid pulse, int_out = 0.
- IR2 in service, ir_req adds IR5 -> int_out stays 0. Add IR1 -> int_out = 1 (nesting). Acknowledge -> isr = 8'h06, vec_out = 8'hA9.
- aeoi_en = 1, rotate_en = 1, IR3 acknowledged -> isr = 0 after the second pulse and low_prio = 3. Then IR2 and IR4 pending together -> win = 4, vec_out = 8'hAC.
- Non-specific EOI with isr = 8'h0A -> isr = 8'h08. Specific EOI with eoi_level = 3 -> isr = 0. Specific EOI with rotate -> low_prio = 3.
- Spurious case: IR6 pending, then masked between int_out and the first inta_pulse -> vec_out = 8'hAF and isr unchanged at 0.
- NUM_IR = 16, VEC_W = 8, vec_base = 8'h40, IR12 raised in level mode -> vec_out = 8'h4C. Dropping ir_req[12] before INTA removes irr[12] and deasserts int_out. Asserting rst_n = 0 between the two pulses -> no vec_valid, all outputs at reset values.

Source files
------------

// File: rtl/pic_ctrl_core.sv
// pic_ctrl_core: single-clock interrupt-controller core.
// Holds IRR/ISR, resolves the highest-priority unmasked request under a
// rotating priority scheme, runs the two-pulse INTA handshake, emits the
// vector, and services non-specific EOI, specific EOI and automatic EOI.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ir_req           synchronised interrupt request lines
//   ltim             1 = level-triggered, 0 = edge-triggered
//   aeoi_en          automatic EOI at the second INTA
//   imr              interrupt mask (1 = masked)
//   vec_base         vector base; low IDX_W bits replaced by the level
//   inta_pulse       one-cycle strobe per CPU INTA
//   eoi_cmd          EOI strobe, qualified by eoi_specific / eoi_level
//   rotate_en        rotate priority on EOI / AEOI clear
//   int_out          registered interrupt request to the CPU
//   vec_out          registered vector, qualified by vec_valid
//   irr, isr         request and in-service registers
//   low_prio         current lowest-priority level
module pic_ctrl_core #(
    parameter int unsigned  NUM_IR = 8,
    parameter int unsigned  VEC_W  = 8,
    localparam int unsigned IDX_W  = $clog2(NUM_IR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir_req,
    input  logic              ltim,
    input  logic              aeoi_en,
    input  logic [NUM_IR-1:0] imr,
    input  logic [VEC_W-1:0]  vec_base,
    input  logic              inta_pulse,
    input  logic              eoi_cmd,
    input  logic              eoi_specific,
    input  logic [IDX_W-1:0]  eoi_level,
    input  logic              rotate_en,
    output logic              int_out,
    output logic [VEC_W-1:0]  vec_out,
    output logic              vec_valid,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr,
    output logic [IDX_W-1:0]  low_prio
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_IR-1:0]   irr_q, irr_d;
    logic [NUM_IR-1:0]   isr_q, isr_d;
    logic [NUM_IR-1:0]   ir_prev_q;
    logic [IDX_W-1:0]    low_prio_q, low_prio_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                spur_q, spur_d;
    logic                int_out_q, int_out_d;
    logic [VEC_W-1:0]    vec_out_q, vec_out_d;
    logic                vec_valid_q, vec_valid_d;

    logic [NUM_IR-1:0]   pend;
    logic                win_vld, top_vld;
    logic [IDX_W-1:0]    win_idx, top_idx;
    logic [IDX_W-1:0]    win_rank, top_rank;
    logic [NUM_IR-1:0]   isr_set, isr_clr, ack_clr;
    logic                int_force;

    // Low IDX_W bits of vec_base are replaced by the level number.
    logic                unused_vec_base_lsbs;
    assign unused_vec_base_lsbs = ^vec_base[IDX_W-1:0];

    assign pend = irr_q & ~imr;

    // Rotating-priority resolution; rank 0 is the highest priority.
    // Walk from lowest to highest so the last hit is the winner.
    always_comb begin
        logic [IDX_W-1:0] lvl;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_rank = '0;
        top_vld  = 1'b0;
        top_idx  = '0;
        top_rank = '0;
        lvl      = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            lvl = low_prio_q + IDX_W'(1) + IDX_W'(i);
            if (pend[lvl]) begin
                win_vld  = 1'b1;
                win_idx  = lvl;
                win_rank = IDX_W'(i);
            end
            if (isr_q[lvl]) begin
                top_vld  = 1'b1;
                top_idx  = lvl;
                top_rank = IDX_W'(i);
            end
        end
    end

    // Next-state, handshake, EOI and register update logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spur_d      = spur_q;
        vec_out_d   = vec_out_q;
        vec_valid_d = 1'b0;
        low_prio_d  = low_prio_q;
        isr_set     = '0;
        isr_clr     = '0;
        ack_clr     = '0;

        // EOI uses the pre-update ISR for its top-level lookup.
        if (eoi_cmd) begin
            if (eoi_specific) begin
                isr_clr[eoi_level] = 1'b1;
                if (rotate_en) begin
                    low_prio_d = eoi_level;
                end
            end else if (top_vld) begin
                isr_clr[top_idx] = 1'b1;
                if (rotate_en) begin
                    low_prio_d = top_idx;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (inta_pulse) begin
                    state_d = ST_ACK1;
                    if (win_vld) begin
                        idx_d            = win_idx;
                        spur_d           = 1'b0;
                        isr_set[win_idx] = 1'b1;
                        ack_clr[win_idx] = 1'b1;
                    end else begin
                        idx_d  = IDX_W'(NUM_IR - 1);
                        spur_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_pulse) begin
                    state_d     = ST_IDLE;
                    vec_out_d   = {vec_base[VEC_W-1:IDX_W], idx_q};
                    vec_valid_d = 1'b1;
                    if (aeoi_en && !spur_q) begin
                        isr_clr[idx_q] = 1'b1;
                        if (rotate_en) begin
                            low_prio_d = idx_q;
                        end
                    end
                end
            end
            ST_ACK2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Set beats clear when both hit the same ISR bit.
        isr_d = (isr_q & ~isr_clr) | isr_set;

        // Acknowledge beats a simultaneous new edge or a held level.
        if (ltim) begin
            irr_d = ir_req & ~ack_clr;
        end else begin
            irr_d = (irr_q | (ir_req & ~ir_prev_q)) & ~ack_clr;
        end

        // INT is held low through the handshake and the vector cycle.
        int_force = inta_pulse || (state_q != ST_IDLE) || vec_valid_q;
        int_out_d = !int_force && win_vld && (!top_vld || (win_rank < top_rank));
    end

    // State and register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            ir_prev_q   <= '0;
            low_prio_q  <= IDX_W'(NUM_IR - 1);
            idx_q       <= '0;
            spur_q      <= 1'b0;
            int_out_q   <= 1'b0;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            ir_prev_q   <= ir_req;
            low_prio_q  <= low_prio_d;
            idx_q       <= idx_d;
            spur_q      <= spur_d;
            int_out_q   <= int_out_d;
            vec_out_q   <= vec_out_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign int_out   = int_out_q;
    assign vec_out   = vec_out_q;
    assign vec_valid = vec_valid_q;
    assign irr       = irr_q;
    assign isr       = isr_q;
    assign low_prio  = low_prio_q;

endmodule

// File: tb/tb_pic_ctrl_core.sv
// Directed bench for pic_ctrl_core: an 8-level edge-mode instance and a
// 16-level level-mode instance sharing clock, reset and EOI strobes.
module tb_pic_ctrl_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aeoi_en, eoi_cmd, eoi_specific, rotate_en;

    logic [7:0]  a_ir, a_imr, a_vb, a_vec, a_irr, a_isr;
    logic        a_ltim, a_inta, a_int, a_vv;
    logic [2:0]  a_eoi_lvl, a_lp;

    logic [15:0] b_ir, b_imr, b_irr, b_isr;
    logic [7:0]  b_vb, b_vec;
    logic        b_ltim, b_inta, b_int, b_vv;
    logic [3:0]  b_eoi_lvl, b_lp;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pic_ctrl_core #(.NUM_IR(8), .VEC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ir_req(a_ir), .ltim(a_ltim), .aeoi_en(aeoi_en),
        .imr(a_imr), .vec_base(a_vb), .inta_pulse(a_inta), .eoi_cmd(eoi_cmd),
        .eoi_specific(eoi_specific), .eoi_level(a_eoi_lvl), .rotate_en(rotate_en),
        .int_out(a_int), .vec_out(a_vec), .vec_valid(a_vv), .irr(a_irr),
        .isr(a_isr), .low_prio(a_lp)
    );

    pic_ctrl_core #(.NUM_IR(16), .VEC_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ir_req(b_ir), .ltim(b_ltim), .aeoi_en(aeoi_en),
        .imr(b_imr), .vec_base(b_vb), .inta_pulse(b_inta), .eoi_cmd(eoi_cmd),
        .eoi_specific(eoi_specific), .eoi_level(b_eoi_lvl), .rotate_en(rotate_en),
        .int_out(b_int), .vec_out(b_vec), .vec_valid(b_vv), .irr(b_irr),
        .isr(b_isr), .low_prio(b_lp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pulse();
        a_inta = 1'b1;
        tick();
        a_inta = 1'b0;
    endtask

    task automatic b_pulse();
        b_inta = 1'b1;
        tick();
        b_inta = 1'b0;
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        eoi_cmd      = 1'b1;
        eoi_specific = spec;
        a_eoi_lvl    = lvl;
        rotate_en    = rot;
        tick();
        eoi_cmd      = 1'b0;
        rotate_en    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        aeoi_en = 1'b0; eoi_cmd = 1'b0; eoi_specific = 1'b0; rotate_en = 1'b0;
        a_ir = '0; a_imr = '0; a_vb = 8'hA8; a_ltim = 1'b0; a_inta = 1'b0; a_eoi_lvl = '0;
        b_ir = '0; b_imr = '0; b_vb = 8'h40; b_ltim = 1'b1; b_inta = 1'b0; b_eoi_lvl = '0;
        tick(); tick();
        chk("rst_irr", 32'(a_irr), 32'h00);
        chk("rst_isr", 32'(a_isr), 32'h00);
        chk("rst_int", 32'(a_int), 32'h0);
        chk("rst_vv", 32'(a_vv), 32'h0);
        chk("rst_lp", 32'(a_lp), 32'h7);
        chk("rst_lp16", 32'(b_lp), 32'hF);
        rst_n = 1'b1;
        tick();

        // Basic edge request on IR2
        a_ir = 8'h04;
        tick();
        chk("t1_irr", 32'(a_irr), 32'h04);
        tick();
        chk("t1_int", 32'(a_int), 32'h1);
        a_pulse();
        chk("t1_isr", 32'(a_isr), 32'h04);
        chk("t1_irr_ack", 32'(a_irr), 32'h00);
        chk("t1_int_low", 32'(a_int), 32'h0);
        tick();
        a_pulse();
        chk("t1_vv", 32'(a_vv), 32'h1);
        chk("t1_vec", 32'(a_vec), 32'hAA);
        tick();
        chk("t1_vv_once", 32'(a_vv), 32'h0);
        tick(); tick();
        chk("t1_int_idle", 32'(a_int), 32'h0);

        // Nesting: IR5 lower than IR2 is held, IR1 higher interrupts
        a_ir = 8'h24;
        tick(); tick(); tick();
        chk("t2_irr5", 32'(a_irr), 32'h20);
        chk("t2_int_blocked", 32'(a_int), 32'h0);
        a_ir = 8'h26;
        tick(); tick();
        chk("t2_int_nest", 32'(a_int), 32'h1);
        a_pulse();
        chk("t2_isr", 32'(a_isr), 32'h06);
        tick();
        a_pulse();
        chk("t2_vec", 32'(a_vec), 32'hA9);
        a_imr = 8'h20;
        tick();
        eoi(1'b0, 3'd0, 1'b0);
        chk("t2_eoi1", 32'(a_isr), 32'h04);
        eoi(1'b0, 3'd0, 1'b0);
        chk("t2_eoi2", 32'(a_isr), 32'h00);

        // AEOI with rotation
        aeoi_en = 1'b1; rotate_en = 1'b1;
        a_ir = 8'h2E;
        tick(); tick();
        chk("t3_irr", 32'(a_irr), 32'h28);
        chk("t3_int", 32'(a_int), 32'h1);
        a_pulse();
        chk("t3_isr_set", 32'(a_isr), 32'h08);
        tick();
        rotate_en = 1'b1;
        a_pulse();
        chk("t3_vec", 32'(a_vec), 32'hAB);
        chk("t3_isr_aeoi", 32'(a_isr), 32'h00);
        chk("t3_lp", 32'(a_lp), 32'h3);
        a_ir = 8'h00;
        tick();
        a_ir = 8'h14;
        tick(); tick();
        chk("t3_int2", 32'(a_int), 32'h1);
        a_pulse();
        tick();
        a_pulse();
        chk("t3_vec_rot", 32'(a_vec), 32'hAC);
        chk("t3_lp4", 32'(a_lp), 32'h4);
        chk("t3_irr_left", 32'(a_irr), 32'h24);
        aeoi_en = 1'b0; rotate_en = 1'b0;
        tick(); tick();

        // EOI variants with isr = 0A under low_prio = 4
        a_imr = 8'h24;
        a_ir = 8'h00;
        tick();
        a_ir = 8'h0A;
        tick(); tick();
        a_pulse();
        chk("t4_isr_ir1", 32'(a_isr), 32'h02);
        tick();
        a_pulse();
        chk("t4_vec1", 32'(a_vec), 32'hA9);
        tick(); tick();
        a_pulse();
        tick();
        a_pulse();
        chk("t4_vec3", 32'(a_vec), 32'hAB);
        chk("t4_isr", 32'(a_isr), 32'h0A);
        eoi(1'b0, 3'd0, 1'b0);
        chk("t4_ns_eoi", 32'(a_isr), 32'h08);
        eoi(1'b1, 3'd3, 1'b0);
        chk("t4_sp_eoi", 32'(a_isr), 32'h00);
        chk("t4_lp_keep", 32'(a_lp), 32'h4);
        eoi(1'b1, 3'd3, 1'b1);
        chk("t4_sp_rot", 32'(a_lp), 32'h3);

        // Spurious acknowledge: IR6 masked after INT
        a_ir = 8'h4A;
        tick(); tick();
        chk("t5_int", 32'(a_int), 32'h1);
        a_imr = 8'h64;
        a_pulse();
        chk("t5_isr", 32'(a_isr), 32'h00);
        tick();
        a_pulse();
        chk("t5_vv", 32'(a_vv), 32'h1);
        chk("t5_vec", 32'(a_vec), 32'hAF);
        chk("t5_isr2", 32'(a_isr), 32'h00);
        chk("t5_irr", 32'(a_irr), 32'h64);

        // 16-level instance in level mode
        b_ir = 16'h1000;
        tick();
        chk("t6_irr", 32'(b_irr), 32'h1000);
        tick();
        chk("t6_int", 32'(b_int), 32'h1);
        b_ir = 16'h0000;
        tick();
        chk("t6_irr_drop", 32'(b_irr), 32'h0000);
        tick();
        chk("t6_int_drop", 32'(b_int), 32'h0);
        b_ir = 16'h1000;
        tick(); tick();
        chk("t6_int2", 32'(b_int), 32'h1);
        b_pulse();
        chk("t6_isr", 32'(b_isr), 32'h1000);
        chk("t6_irr_ack", 32'(b_irr), 32'h0000);
        tick();
        b_pulse();
        chk("t6_vv", 32'(b_vv), 32'h1);
        chk("t6_vec", 32'(b_vec), 32'h4C);
        tick(); tick();

        // Reset between the two pulses
        b_pulse();
        tick();
        rst_n = 1'b0;
        #2;
        chk("t7_vv", 32'(b_vv), 32'h0);
        chk("t7_vec", 32'(b_vec), 32'h00);
        chk("t7_isr", 32'(b_isr), 32'h0000);
        chk("t7_irr", 32'(b_irr), 32'h0000);
        chk("t7_int", 32'(b_int), 32'h0);
        chk("t7_lp", 32'(b_lp), 32'hF);
        chk("t7_lp8", 32'(a_lp), 32'h7);
        b_ir = '0;
        a_ir = '0;
        tick();
        rst_n = 1'b1;
        tick();
        b_pulse();
        chk("t7_no_vec", 32'(b_vv), 32'h0);
        tick();
        chk("t7_no_vec2", 32'(b_vv), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
